// File: rtl/cpu_fetch.sv
// Instruction fetch stage: issues in-order imem requests, buffers responses in a
// two-entry FIFO and presents them to decode with stall and redirect handling.
module cpu_fetch #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     PC_STEP   = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] next_PC,
    output logic            instr_valid
);

    localparam int unsigned DEPTH = 2;

    logic [XLEN-1:0] fetch_pc;
    logic [1:0]      outstanding;
    logic [1:0]      drop_cnt;

    logic [XLEN-1:0] aq_addr [DEPTH];
    logic            aq_wr;
    logic            aq_rd;

    logic [XLEN-1:0] fifo_instr [DEPTH];
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic            fifo_wr;
    logic            fifo_rd;
    logic [1:0]      fifo_cnt;

    logic req_hs;
    logic resp_ok;
    logic resp_keep;
    logic pop;

    // Request gating keeps fifo_cnt + outstanding <= DEPTH, so the FIFO cannot overflow.
    always_comb begin
        imem_req_valid = reset && !redirect_valid &&
                         (({1'b0, fifo_cnt} + {1'b0, outstanding}) < 3'(DEPTH));
        imem_req_addr  = fetch_pc;
        req_hs         = imem_req_valid && imem_req_ready;
        resp_ok        = imem_resp_valid && (outstanding != 2'd0);
        resp_keep      = resp_ok && !redirect_valid && (drop_cnt == 2'd0);
        pop            = !redirect_valid && !stall && (fifo_cnt != 2'd0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            aq_wr       <= 1'b0;
            aq_rd       <= 1'b0;
            fifo_wr     <= 1'b0;
            fifo_rd     <= 1'b0;
            fifo_cnt    <= '0;
            instr       <= NOP_INSTR;
            PC          <= '0;
            next_PC     <= '0;
            instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            // Everything still in flight at this point belongs to the wrong path.
            fetch_pc    <= redirect_pc;
            outstanding <= outstanding - 2'(resp_ok);
            drop_cnt    <= outstanding - 2'(resp_ok);
            aq_wr       <= 1'b0;
            aq_rd       <= 1'b0;
            fifo_wr     <= 1'b0;
            fifo_rd     <= 1'b0;
            fifo_cnt    <= '0;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else begin
            if (req_hs) begin
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                aq_wr    <= ~aq_wr;
            end
            outstanding <= outstanding + 2'(req_hs) - 2'(resp_ok);
            if (resp_ok && (drop_cnt != 2'd0)) begin
                drop_cnt <= drop_cnt - 2'd1;
            end
            if (resp_keep) begin
                aq_rd   <= ~aq_rd;
                fifo_wr <= ~fifo_wr;
            end
            fifo_cnt <= fifo_cnt + 2'(resp_keep) - 2'(pop);
            if (pop) begin
                fifo_rd     <= ~fifo_rd;
                instr       <= fifo_instr[fifo_rd];
                PC          <= fifo_pc[fifo_rd];
                next_PC     <= fifo_pc[fifo_rd] + XLEN'(PC_STEP);
                instr_valid <= 1'b1;
            end else if (!stall) begin
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end
    end

    // Payload storage; validity is tracked by the pointers and counters above.
    always_ff @(posedge clock) begin
        if (req_hs) begin
            aq_addr[aq_wr] <= fetch_pc;
        end
        if (resp_keep) begin
            fifo_instr[fifo_wr] <= imem_resp_data;
            fifo_pc[fifo_wr]    <= aq_addr[aq_rd];
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_cpu_fetch;

    localparam logic [31:0] NOP    = 32'h0;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] PC;
    logic [31:0] next_PC;
    logic        instr_valid;

    cpu_fetch #(
        .XLEN(32), .RESET_PC(RST_PC), .PC_STEP(4), .NOP_INSTR(NOP)
    ) dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr(instr), .PC(PC), .next_PC(next_PC), .instr_valid(instr_valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed { logic [31:0] addr; logic drop; } flight_t;
    typedef struct packed { logic [31:0] data; logic [31:0] pc; } entry_t;

    // Reference model: requests in flight and buffered responses as plain queues.
    flight_t     m_flight[$];
    entry_t      m_ready[$];
    logic [31:0] m_fetch_pc, m_instr, m_pc, m_npc;
    logic        m_valid;

    logic [31:0] mem_q[$];
    logic [31:0] out_log[$];
    logic [31:0] out_instr_log[$];
    logic        mem_en, spurious, dut_hs;
    int          n_pass, n_total, hs_cnt;
    logic [31:0] snap_pc, snap_instr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic m_req_valid();
        return reset && !redirect_valid && ((m_ready.size() + m_flight.size()) < 2);
    endfunction

    function automatic void model_reset();
        m_flight.delete();
        m_ready.delete();
        m_fetch_pc = RST_PC;
        m_instr    = NOP;
        m_pc       = '0;
        m_npc      = '0;
        m_valid    = 1'b0;
    endfunction

    function automatic void model_edge();
        logic    hs, resp;
        flight_t f;
        entry_t  e;
        hs   = m_req_valid() && imem_req_ready;
        resp = imem_resp_valid && (m_flight.size() > 0);
        if (redirect_valid) begin
            if (resp) void'(m_flight.pop_front());
            foreach (m_flight[i]) m_flight[i].drop = 1'b1;
            m_ready.delete();
            m_fetch_pc = redirect_pc;
            m_instr    = NOP;
            m_valid    = 1'b0;
        end else begin
            if (!stall) begin
                if (m_ready.size() > 0) begin
                    e       = m_ready.pop_front();
                    m_instr = e.data;
                    m_pc    = e.pc;
                    m_npc   = e.pc + 32'd4;
                    m_valid = 1'b1;
                end else begin
                    m_instr = NOP;
                    m_valid = 1'b0;
                end
            end
            if (resp) begin
                f = m_flight.pop_front();
                if (!f.drop) begin
                    e.data = imem_resp_data;
                    e.pc   = f.addr;
                    m_ready.push_back(e);
                end
            end
            if (hs) begin
                f.addr = m_fetch_pc;
                f.drop = 1'b0;
                m_flight.push_back(f);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
    endfunction

    // One clock cycle: drive memory response, check request side, advance model, check outputs.
    task automatic step();
        logic        use_mem, st;
        logic [31:0] hs_addr;
        use_mem         = mem_en && (mem_q.size() > 0);
        imem_resp_valid = use_mem || (spurious && (mem_q.size() == 0));
        imem_resp_data  = use_mem ? (mem_q[0] + 32'h100) : 32'hDEAD_BEEF;
        #1;
        check("req_valid", 32'(imem_req_valid), 32'(m_req_valid()));
        if (m_req_valid()) check("req_addr", imem_req_addr, m_fetch_pc);
        dut_hs  = imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;
        st      = stall || redirect_valid;
        model_edge();
        @(posedge clock);
        if (use_mem) void'(mem_q.pop_front());
        if (dut_hs) mem_q.push_back(hs_addr);
        #1;
        imem_resp_valid = 1'b0;
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("instr", instr, m_instr);
        check("pc", PC, m_pc);
        check("next_pc", next_PC, m_npc);
        if (instr_valid && !st) begin
            out_log.push_back(PC);
            out_instr_log.push_back(instr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass = 0; n_total = 0; hs_cnt = 0;
        reset = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_en = 1'b0; spurious = 1'b0; dut_hs = 1'b0;
        model_reset();
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_pc", PC, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Memory not ready; stray responses with nothing outstanding are ignored.
        spurious = 1'b1;
        repeat (5) begin
            step();
            check("a_hold_addr", imem_req_addr, 32'h0);
            check("a_no_output", 32'(instr_valid), 32'd0);
        end
        spurious = 1'b0;

        // Single-cycle memory returning addr+0x100.
        imem_req_ready = 1'b1; mem_en = 1'b1;
        out_log.delete(); out_instr_log.delete();
        repeat (12) step();
        check("b_count", 32'(out_log.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < out_log.size(); i++) begin
            check("b_pc", out_log[i], 32'(i * 4));
            check("b_instr", out_instr_log[i], 32'h100 + 32'(i * 4));
        end

        // Ready low: FIFO drains to bubbles.
        imem_req_ready = 1'b0;
        repeat (5) step();
        check("c_bubble_valid", 32'(instr_valid), 32'd0);
        check("c_bubble_instr", instr, NOP);

        // Stall with memory responding: outputs frozen, nothing lost or duplicated.
        imem_req_ready = 1'b1;
        out_log.delete(); out_instr_log.delete();
        repeat (3) step();
        stall = 1'b1; snap_pc = PC; snap_instr = instr; hs_cnt = 0;
        repeat (3) begin
            step();
            hs_cnt += 32'(dut_hs);
            check("d_frozen_pc", PC, snap_pc);
            check("d_frozen_instr", instr, snap_instr);
        end
        check("d_hs_le2", 32'(hs_cnt <= 2), 32'd1);
        stall = 1'b0;
        repeat (10) step();
        check("d_count", 32'(out_log.size() >= 4), 32'd1);
        for (int i = 1; i < out_log.size(); i++) begin
            check("d_seq", out_log[i], out_log[i-1] + 32'd4);
            check("d_data", out_instr_log[i], out_log[i] + 32'h100);
        end

        // Redirect to 0x40 with two requests outstanding.
        mem_en = 1'b0;
        repeat (6) step();
        check("e_outstanding", 32'(mem_q.size()), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0; mem_en = 1'b1;
        check("e_flush_valid", 32'(instr_valid), 32'd0);
        out_log.delete(); out_instr_log.delete();
        repeat (20) step();
        check("e_resume", 32'(out_log.size() > 0), 32'd1);
        if (out_log.size() > 0) check("e_first_pc", out_log[0], 32'h40);
        for (int i = 0; i < out_log.size(); i++)
            check("e_no_stale", 32'(out_log[i] >= 32'h40 && out_log[i] < 32'h80), 32'd1);

        // Redirect together with stall while a response arrives.
        for (int i = 0; i < 10 && mem_q.size() != 1; i++) step();
        check("f_setup", 32'(mem_q.size()), 32'd1);
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        check("f_flush_valid", 32'(instr_valid), 32'd0);
        #1;
        check("f_req_valid", 32'(imem_req_valid), 32'd1);
        check("f_req_addr", imem_req_addr, 32'h80);
        out_log.delete(); out_instr_log.delete();
        repeat (8) step();
        check("f_resume", 32'(out_log.size() > 0), 32'd1);
        if (out_log.size() > 0) check("f_first_pc", out_log[0], 32'h80);

        // Asynchronous reset while the FIFO is full.
        stall = 1'b1;
        for (int i = 0; i < 10 && m_ready.size() != 2; i++) step();
        check("g_full", 32'(m_ready.size()), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("g_rst_valid", 32'(instr_valid), 32'd0);
        check("g_rst_instr", instr, NOP);
        check("g_rst_pc", PC, 32'h0);
        check("g_rst_npc", next_PC, 32'h0);
        check("g_rst_req", 32'(imem_req_valid), 32'd0);
        model_reset();
        mem_q.delete();
        stall = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("g_first_req_valid", 32'(imem_req_valid), 32'd1);
        check("g_first_req_addr", imem_req_addr, RST_PC);
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
